// File: rtl/time_set_controller.sv
// Time-of-day set controller: 1 Hz tick prescaler in RUN, and a button-driven
// hours/minutes/seconds edit sequence issuing BCD load strobes to the counter chain.
module time_set_controller #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        up_btn,
  input  logic        down_btn,
  input  logic [23:0] cur_time,
  output logic        sec_tick,
  output logic        load_sec,
  output logic        load_min,
  output logic        load_hr,
  output logic [7:0]  new_value,
  output logic [2:0]  edit_field,
  output logic [23:0] display_data
);

  localparam int unsigned        CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       edit_value_q;
  logic [7:0]       new_value_q;
  logic [2:0]       edit_field_q;
  logic             sec_tick_q, load_sec_q, load_min_q, load_hr_q;
  logic             mode_q, up_q, down_q;

  logic             mode_edge, up_edge, down_edge, adj_en;
  logic [7:0]       field_max, edit_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)            return 8'h00;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)          return max;
    else if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                     return {v[7:4], v[3:0] - 4'h1};
  endfunction

  always_comb begin
    mode_edge = mode_btn & ~mode_q;
    up_edge   = up_btn   & ~up_q;
    down_edge = down_btn & ~down_q;
    // Simultaneous up and down cancel; a mode edge overrides both in the FSM.
    adj_en    = up_edge ^ down_edge;
    field_max = (state_q == SET_HR) ? 8'h23 : 8'h59;
    edit_d    = up_edge ? bcd_inc(edit_value_q, field_max)
                        : bcd_dec(edit_value_q, field_max);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      edit_value_q <= '0;
      new_value_q  <= '0;
      edit_field_q <= '0;
      sec_tick_q   <= 1'b0;
      load_sec_q   <= 1'b0;
      load_min_q   <= 1'b0;
      load_hr_q    <= 1'b0;
      mode_q       <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else begin
      mode_q     <= mode_btn;
      up_q       <= up_btn;
      down_q     <= down_btn;
      sec_tick_q <= 1'b0;
      load_sec_q <= 1'b0;
      load_min_q <= 1'b0;
      load_hr_q  <= 1'b0;
      case (state_q)
        RUN: begin
          if (mode_edge) begin
            state_q      <= SET_HR;
            edit_value_q <= cur_time[23:16];
            edit_field_q <= 3'b100;
            cnt_q        <= '0;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q      <= '0;
            sec_tick_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SET_HR: begin
          if (mode_edge) begin
            state_q      <= SET_MIN;
            load_hr_q    <= 1'b1;
            new_value_q  <= edit_value_q;
            edit_value_q <= cur_time[15:8];
            edit_field_q <= 3'b010;
          end else if (adj_en) begin
            edit_value_q <= edit_d;
          end
        end
        SET_MIN: begin
          if (mode_edge) begin
            state_q      <= SET_SEC;
            load_min_q   <= 1'b1;
            new_value_q  <= edit_value_q;
            edit_value_q <= cur_time[7:0];
            edit_field_q <= 3'b001;
          end else if (adj_en) begin
            edit_value_q <= edit_d;
          end
        end
        SET_SEC: begin
          if (mode_edge) begin
            state_q      <= RUN;
            load_sec_q   <= 1'b1;
            new_value_q  <= edit_value_q;
            edit_field_q <= 3'b000;
            cnt_q        <= '0;
          end else if (adj_en) begin
            edit_value_q <= edit_d;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    display_data = cur_time;
    case (state_q)
      SET_HR:  display_data[23:16] = edit_value_q;
      SET_MIN: display_data[15:8]  = edit_value_q;
      SET_SEC: display_data[7:0]   = edit_value_q;
      default: display_data        = cur_time;
    endcase
  end

  assign sec_tick   = sec_tick_q;
  assign load_sec   = load_sec_q;
  assign load_min   = load_min_q;
  assign load_hr    = load_hr_q;
  assign new_value  = new_value_q;
  assign edit_field = edit_field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: table-driven button vectors with a cycle-tagged
// scoreboard, plus hand-written tick, held-button and reset-mid-edit sequences.
module tb_time_set_controller;

  localparam int unsigned DIV = 4;

  logic        clock = 1'b0;
  logic        reset, mode_btn, up_btn, down_btn;
  logic [23:0] cur_time;
  logic        sec_tick, load_sec, load_min, load_hr;
  logic [7:0]  new_value;
  logic [2:0]  edit_field;
  logic [23:0] display_data;

  time_set_controller #(.CLK_DIV(DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode_btn     (mode_btn),
    .up_btn       (up_btn),
    .down_btn     (down_btn),
    .cur_time     (cur_time),
    .sec_tick     (sec_tick),
    .load_sec     (load_sec),
    .load_min     (load_min),
    .load_hr      (load_hr),
    .new_value    (new_value),
    .edit_field   (edit_field),
    .display_data (display_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m, u, d;
    logic [2:0]  ld;    // {load_hr, load_min, load_sec}
    logic [7:0]  nv;
    logic [2:0]  fld;
    logic [23:0] disp;
    bit          exit_run;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [2:0]  ld;
    logic [7:0]  nv;
    logic [2:0]  fld;
    logic [23:0] disp;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Decimal reference for the BCD edit arithmetic.
  function automatic logic [7:0] bcd_step(logic [7:0] v, int max, bit up);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (up) d = (d == max) ? 0 : d + 1;
    else    d = (d == 0) ? max : d - 1;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic vec_t mk(logic m, logic u, logic d, logic [2:0] ld, logic [7:0] nv,
                              logic [2:0] fld, logic [23:0] disp, bit ex);
    vec_t v;
    v.m = m; v.u = u; v.d = d; v.ld = ld; v.nv = nv; v.fld = fld; v.disp = disp;
    v.exit_run = ex;
    return v;
  endfunction

  function automatic sb_t mk_sb(int unsigned due, logic [2:0] ld, logic [7:0] nv,
                                logic [2:0] fld, logic [23:0] disp);
    sb_t s;
    s.due = due; s.ld = ld; s.nv = nv; s.fld = fld; s.disp = disp;
    return s;
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check("strobes",    {29'd0, load_hr, load_min, load_sec}, {29'd0, e.ld});
      check("new_value",  {24'd0, new_value},    {24'd0, e.nv});
      check("edit_field", {29'd0, edit_field},   {29'd0, e.fld});
      check("display",    {8'd0, display_data},  {8'd0, e.disp});
      check("no_tick_set", {31'd0, sec_tick}, 32'd0);
    end
  end

  task automatic check_tick(string name, int unsigned exp);
    int unsigned n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sec_tick !== 1'b1 && n < 4 * DIV);
    check(name, n, exp);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      if (i > 0 && vecs[i-1].ld != 3'b000)
        check("strobe_one_cycle", {29'd0, load_hr, load_min, load_sec}, 32'd0);
      mode_btn = vecs[i].m;
      up_btn   = vecs[i].u;
      down_btn = vecs[i].d;
      sb.push_back(mk_sb(cyc + 1, vecs[i].ld, vecs[i].nv, vecs[i].fld, vecs[i].disp));
      @(negedge clock);
      mode_btn = 1'b0;
      up_btn   = 1'b0;
      down_btn = 1'b0;
      if (vecs[i].exit_run) check_tick("tick_after_load_sec", DIV);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ev;
    reset = 1'b1; mode_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
    cur_time = 24'h123456;
    repeat (3) @(negedge clock);
    check("rst_tick",    {31'd0, sec_tick}, 32'd0);
    check("rst_strobes", {29'd0, load_hr, load_min, load_sec}, 32'd0);
    check("rst_nv",      {24'd0, new_value}, 32'd0);
    check("rst_field",   {29'd0, edit_field}, 32'd0);
    check("rst_display", {8'd0, display_data}, 32'h00123456);
    reset = 1'b0;

    check_tick("first_tick", DIV);
    for (int k = 0; k < 3; k++) begin
      check_tick("tick_period", DIV);
      check("run_field",   {29'd0, edit_field}, 32'd0);
      check("run_strobes", {29'd0, load_hr, load_min, load_sec}, 32'd0);
    end
    cur_time = 24'h235959;
    #1 check("run_display", {8'd0, display_data}, 32'h00235959);
    cur_time = 24'h123456;

    // Full set sequence.
    vecs.push_back(mk(1,0,0, 3'b000, 8'h00, 3'b100, 24'h123456, 0));
    ev = 8'h12;
    for (int k = 0; k < 12; k++) begin
      ev = bcd_step(ev, 23, 1);
      vecs.push_back(mk(0,1,0, 3'b000, 8'h00, 3'b100, {ev, 16'h3456}, 0));
    end
    vecs.push_back(mk(1,0,0, 3'b100, 8'h00, 3'b010, 24'h123456, 0));
    ev = 8'h34;
    for (int k = 0; k < 35; k++) begin
      ev = bcd_step(ev, 59, 0);
      vecs.push_back(mk(0,0,1, 3'b000, 8'h00, 3'b010, {8'h12, ev, 8'h56}, 0));
    end
    vecs.push_back(mk(0,1,0, 3'b000, 8'h00, 3'b010, 24'h120056, 0));
    vecs.push_back(mk(0,0,1, 3'b000, 8'h00, 3'b010, 24'h125956, 0));
    vecs.push_back(mk(1,0,0, 3'b010, 8'h59, 3'b001, 24'h123456, 0));
    vecs.push_back(mk(0,1,0, 3'b000, 8'h59, 3'b001, 24'h123457, 0));
    vecs.push_back(mk(1,0,0, 3'b001, 8'h57, 3'b000, 24'h123456, 1));
    run_vecs();

    // BCD boundaries in hours, cancelling edges, mode-priority loads.
    vecs.push_back(mk(1,0,0, 3'b000, 8'h57, 3'b100, 24'h123456, 0));
    vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, 24'h113456, 0));
    vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, 24'h103456, 0));
    vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, 24'h093456, 0));
    vecs.push_back(mk(0,1,0, 3'b000, 8'h57, 3'b100, 24'h103456, 0));
    vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, 24'h093456, 0));
    ev = 8'h09;
    for (int k = 0; k < 9; k++) begin
      ev = bcd_step(ev, 23, 0);
      vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, {ev, 16'h3456}, 0));
    end
    vecs.push_back(mk(0,0,1, 3'b000, 8'h57, 3'b100, 24'h233456, 0));
    vecs.push_back(mk(0,1,0, 3'b000, 8'h57, 3'b100, 24'h003456, 0));
    vecs.push_back(mk(0,1,1, 3'b000, 8'h57, 3'b100, 24'h003456, 0));
    vecs.push_back(mk(0,1,0, 3'b000, 8'h57, 3'b100, 24'h013456, 0));
    vecs.push_back(mk(1,1,0, 3'b100, 8'h01, 3'b010, 24'h123456, 0));
    ev = 8'h34;
    for (int k = 0; k < 27; k++) begin
      ev = bcd_step(ev, 59, 0);
      vecs.push_back(mk(0,0,1, 3'b000, 8'h01, 3'b010, {8'h12, ev, 8'h56}, 0));
    end
    vecs.push_back(mk(1,1,0, 3'b010, 8'h07, 3'b001, 24'h123456, 0));
    vecs.push_back(mk(1,0,0, 3'b001, 8'h56, 3'b000, 24'h123456, 1));
    run_vecs();

    // Held up button: one increment only, no ticks while setting.
    vecs.push_back(mk(1,0,0, 3'b000, 8'h56, 3'b100, 24'h123456, 0));
    run_vecs();
    @(negedge clock);
    up_btn = 1'b1;
    for (int k = 1; k <= 20; k++)
      sb.push_back(mk_sb(cyc + k, 3'b000, 8'h56, 3'b100, 24'h133456));
    repeat (20) @(negedge clock);
    up_btn = 1'b0;
    vecs.push_back(mk(1,0,0, 3'b100, 8'h13, 3'b010, 24'h123456, 0));
    run_vecs();

    // Reset while in SET_MIN abandons the edit.
    @(negedge clock);
    reset = 1'b1;
    sb.push_back(mk_sb(cyc + 1, 3'b000, 8'h00, 3'b000, 24'h123456));
    @(negedge clock);
    reset = 1'b0;
    check_tick("tick_after_reset", DIV);

    @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
